// File: rtl/npc_pkg.sv
// Shared definitions for the next-PC sequencer: FSM state encodings,
// transfer-kind encodings and the default nPC value loaded on reset.
package npc_pkg;

    // Sequencer state: normal flow, delay slot after a taken transfer,
    // or a squashed (annulled) delay-slot instruction.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SLOT   = 2'd1,
        ST_SQUASH = 2'd2
    } npc_state_e;

    // Transfer kind carried on xfer_sel; the reserved code never transfers.
    typedef enum logic [1:0] {
        XFER_BICC = 2'd0,
        XFER_CALL = 2'd1,
        XFER_JMPL = 2'd2,
        XFER_RSVD = 2'd3
    } xfer_sel_e;

    // PC resets to 0, so the first nPC is one instruction further on.
    localparam logic [31:0] RESET_NPC_DEFAULT = 32'h0000_0004;

    // Byte size of one instruction word.
    localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational transfer-target generator: computes the Bicc, CALL and
// JMPL destinations and flags a misaligned JMPL target.
module branch_target_calc
    import npc_pkg::*;
(
    input  logic        cti,
    input  logic [1:0]  xfer_sel,
    input  logic [31:0] pc_in,
    input  logic [21:0] disp22,
    input  logic [29:0] disp30,
    input  logic [31:0] jmpl_target,
    output logic [31:0] target,
    output logic        misalign
);

    logic [31:0] bicc_target;
    logic [31:0] call_target;
    logic [31:0] jmpl_aligned;

    // Form each candidate target; all additions wrap modulo 2^32 and the
    // JMPL address is forced word-aligned so the transfer can still proceed.
    always_comb begin
        bicc_target  = pc_in + {{8{disp22[21]}}, disp22, 2'b00};
        call_target  = pc_in + {disp30, 2'b00};
        jmpl_aligned = {jmpl_target[31:2], 2'b00};
        target       = 32'd0;
        case (xfer_sel_e'(xfer_sel))
            XFER_BICC: target = bicc_target;
            XFER_CALL: target = call_target;
            XFER_JMPL: target = jmpl_aligned;
            default:   target = 32'd0;
        endcase
        misalign = cti && (xfer_sel_e'(xfer_sel) == XFER_JMPL) && (jmpl_target[1:0] != 2'b00);
    end

endmodule

// File: rtl/npc_sequencer.sv
// Next-PC sequencer for a delayed-branch pipeline: holds nPC, tracks delay
// slot / annul state, and selects the value loaded into the PC register.
// The Bicc "always" class flag is carried on bicc_always because "always"
// is a reserved word.
module npc_sequencer
    import npc_pkg::*;
#(
    parameter logic [31:0] RESET_NPC = RESET_NPC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        nPCld,
    input  logic [31:0] pc_in,
    input  logic        cti,
    input  logic [1:0]  xfer_sel,
    input  logic        taken,
    input  logic        bicc_always,
    input  logic        annul_bit,
    input  logic [21:0] disp22,
    input  logic [29:0] disp30,
    input  logic [31:0] jmpl_target,
    input  logic        trap_req,
    input  logic [31:0] tbr,
    output logic [31:0] pc_next,
    output logic [31:0] npc_out,
    output logic        pc_ld,
    output logic        annul_out,
    output logic        delay_slot,
    output logic        misalign
);

    npc_state_e  state_q, state_d;
    logic [31:0] npc_q, npc_d;
    logic [31:0] target;
    logic        eff_xfer;
    logic        squash_slot;

    branch_target_calc u_target (
        .cti         (cti),
        .xfer_sel    (xfer_sel),
        .pc_in       (pc_in),
        .disp22      (disp22),
        .disp30      (disp30),
        .jmpl_target (jmpl_target),
        .target      (target),
        .misalign    (misalign)
    );

    // Register state and nPC; reset throws away any pending transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            npc_q   <= RESET_NPC;
        end else begin
            state_q <= state_d;
            npc_q   <= npc_d;
        end
    end

    // Decide next nPC and state; nothing moves unless an instruction retires.
    always_comb begin
        eff_xfer    = cti && (xfer_sel_e'(xfer_sel) != XFER_RSVD) &&
                      ((xfer_sel_e'(xfer_sel) != XFER_BICC) || taken);
        squash_slot = cti && (xfer_sel_e'(xfer_sel) == XFER_BICC) && annul_bit &&
                      (bicc_always || !taken);
        state_d     = state_q;
        npc_d       = npc_q;
        if (nPCld) begin
            case (state_q)
                ST_SQUASH: begin
                    npc_d   = npc_q + INSTR_BYTES;
                    state_d = ST_RUN;
                end
                default: begin
                    if (trap_req) begin
                        npc_d   = tbr + INSTR_BYTES;
                        state_d = ST_RUN;
                    end else begin
                        npc_d = eff_xfer ? target : (npc_q + INSTR_BYTES);
                        if (squash_slot) begin
                            state_d = ST_SQUASH;
                        end else if (eff_xfer) begin
                            state_d = ST_SLOT;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
            endcase
        end
    end

    // Drive the PC-register interface and the slot status flags.
    always_comb begin
        pc_next    = (trap_req && (state_q != ST_SQUASH)) ? tbr : npc_q;
        pc_ld      = nPCld && !reset;
        npc_out    = npc_q;
        annul_out  = (state_q == ST_SQUASH);
        delay_slot = (state_q == ST_SLOT);
    end

endmodule

// File: tb/tb_npc_sequencer.sv
// Directed self-checking bench for npc_sequencer with hand-computed values.
module tb_npc_sequencer;
    import npc_pkg::*;

    logic        clk;
    logic        reset;
    logic        nPCld;
    logic [31:0] pc_in;
    logic        cti;
    logic [1:0]  xfer_sel;
    logic        taken;
    logic        bicc_always;
    logic        annul_bit;
    logic [21:0] disp22;
    logic [29:0] disp30;
    logic [31:0] jmpl_target;
    logic        trap_req;
    logic [31:0] tbr;
    logic [31:0] pc_next;
    logic [31:0] npc_out;
    logic        pc_ld;
    logic        annul_out;
    logic        delay_slot;
    logic        misalign;

    int numCompared;
    int numMismatched;

    npc_sequencer #(.RESET_NPC(32'h0000_0004)) dut (
        .clk         (clk),
        .reset       (reset),
        .nPCld       (nPCld),
        .pc_in       (pc_in),
        .cti         (cti),
        .xfer_sel    (xfer_sel),
        .taken       (taken),
        .bicc_always (bicc_always),
        .annul_bit   (annul_bit),
        .disp22      (disp22),
        .disp30      (disp30),
        .jmpl_target (jmpl_target),
        .trap_req    (trap_req),
        .tbr         (tbr),
        .pc_next     (pc_next),
        .npc_out     (npc_out),
        .pc_ld       (pc_ld),
        .annul_out   (annul_out),
        .delay_slot  (delay_slot),
        .misalign    (misalign)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one retiring instruction's worth of inputs.
    task automatic applyStimulus(input logic c, input logic [1:0] xs, input logic tk,
                                 input logic alw, input logic an, input logic [31:0] pc,
                                 input logic [21:0] d22, input logic [29:0] d30,
                                 input logic [31:0] jt, input logic tr, input logic [31:0] tb);
        cti         = c;
        xfer_sel    = xs;
        taken       = tk;
        bicc_always = alw;
        annul_bit   = an;
        pc_in       = pc;
        disp22      = d22;
        disp30      = d30;
        jmpl_target = jt;
        trap_req    = tr;
        tbr         = tb;
    endtask

    // Retire with no transfer and no trap.
    task automatic applyIdle();
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0, 22'd0, 30'd0, 32'd0, 1'b0, 32'd0);
    endtask

    // Let one rising edge pass and settle just after it.
    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        numCompared++;
        assert (observed === expected)
        else begin
            numMismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        numCompared   = 0;
        numMismatched = 0;
        reset = 1'b1;
        nPCld = 1'b1;
        applyIdle();

        // Reset state, held across a clock edge with nPCld high.
        #3;
        checkOutput("rst_npc", npc_out, 32'h4);
        checkOutput("rst_pcld", {31'd0, pc_ld}, 32'd0);
        checkOutput("rst_slot", {31'd0, delay_slot}, 32'd0);
        checkOutput("rst_annul", {31'd0, annul_out}, 32'd0);
        stepClock();
        checkOutput("rst_hold_npc", npc_out, 32'h4);
        reset = 1'b0;
        #1;
        checkOutput("pcld_on", {31'd0, pc_ld}, 32'd1);

        // Sequential flow: pc_next 4, 8, 12 and npc_out 8, 12, 16.
        for (int i = 0; i < 3; i++) begin
            checkOutput("seq_pc_next", pc_next, 32'(4 * (i + 1)));
            stepClock();
            checkOutput("seq_npc", npc_out, 32'(4 * (i + 2)));
        end

        // nPCld low freezes everything even with a taken branch presented.
        nPCld = 1'b0;
        applyStimulus(1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 32'h100, 22'h3FFFFC, 30'd0, 32'd0, 1'b0, 32'd0);
        #1;
        checkOutput("hold_pcld", {31'd0, pc_ld}, 32'd0);
        stepClock();
        checkOutput("hold_npc", npc_out, 32'h10);
        checkOutput("hold_slot", {31'd0, delay_slot}, 32'd0);
        nPCld = 1'b1;

        // Bicc taken backwards: 0x100 + (-4 << 2) = 0xF0.
        stepClock();
        checkOutput("bicc_npc", npc_out, 32'hF0);
        checkOutput("bicc_slot", {31'd0, delay_slot}, 32'd1);
        applyIdle();
        #1;
        checkOutput("bicc_pc_next", pc_next, 32'hF0);
        stepClock();
        checkOutput("after_slot_npc", npc_out, 32'hF4);
        checkOutput("after_slot_run", {31'd0, delay_slot}, 32'd0);

        // DCTI couple: a CALL sitting in a delay slot is honoured.
        applyStimulus(1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 32'h200, 22'd2, 30'd0, 32'd0, 1'b0, 32'd0);
        stepClock();
        checkOutput("dcti_first", npc_out, 32'h208);
        applyStimulus(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 32'h1000, 22'd0, 30'd4, 32'd0, 1'b0, 32'd0);
        stepClock();
        checkOutput("dcti_second", npc_out, 32'h1010);
        checkOutput("dcti_slot", {31'd0, delay_slot}, 32'd1);

        // Reach nPC 0x108 via JMPL 0x104, then an annulled untaken Bicc.
        applyStimulus(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 32'h1010, 22'd0, 30'd0, 32'h104, 1'b0, 32'd0);
        stepClock();
        checkOutput("jmpl_npc", npc_out, 32'h104);
        applyIdle();
        stepClock();
        checkOutput("pre_annul_npc", npc_out, 32'h108);
        applyStimulus(1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 32'h104, 22'd40, 30'd0, 32'd0, 1'b0, 32'd0);
        stepClock();
        checkOutput("annul_out", {31'd0, annul_out}, 32'd1);
        checkOutput("annul_npc", npc_out, 32'h10C);
        checkOutput("annul_noslot", {31'd0, delay_slot}, 32'd0);

        // Squashed slot ignores both a CALL and a trap request.
        applyStimulus(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 32'h108, 22'd0, 30'd100, 32'd0, 1'b1, 32'h800);
        #1;
        checkOutput("squash_pc_next", pc_next, 32'h10C);
        stepClock();
        checkOutput("squash_npc", npc_out, 32'h110);
        checkOutput("squash_clear", {31'd0, annul_out}, 32'd0);
        checkOutput("squash_run", {31'd0, delay_slot}, 32'd0);

        // CALL target wraps: 0xFFFFFFF0 + 0x20 = 0x10.
        applyStimulus(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF0, 22'd0, 30'd8, 32'd0, 1'b0, 32'd0);
        stepClock();
        checkOutput("call_wrap", npc_out, 32'h10);

        // Misaligned JMPL still transfers to the aligned address.
        applyStimulus(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 32'h10, 22'd0, 30'd0, 32'h203, 1'b0, 32'd0);
        #1;
        checkOutput("misalign_hi", {31'd0, misalign}, 32'd1);
        stepClock();
        checkOutput("jmpl_aligned", npc_out, 32'h200);
        checkOutput("jmpl_slot", {31'd0, delay_slot}, 32'd1);

        // Reserved transfer kind behaves as no transfer; misalign drops.
        applyStimulus(1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 32'h200, 22'd0, 30'd0, 32'h203, 1'b0, 32'd0);
        #1;
        checkOutput("misalign_lo", {31'd0, misalign}, 32'd0);
        stepClock();
        checkOutput("rsvd_npc", npc_out, 32'h204);
        checkOutput("rsvd_run", {31'd0, delay_slot}, 32'd0);

        // BA,a: transfer happens and the delay slot is annulled.
        applyStimulus(1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 32'h300, 22'd4, 30'd0, 32'd0, 1'b0, 32'd0);
        stepClock();
        checkOutput("ba_a_npc", npc_out, 32'h310);
        checkOutput("ba_a_annul", {31'd0, annul_out}, 32'd1);
        applyIdle();
        stepClock();
        checkOutput("ba_a_after", npc_out, 32'h314);

        // Trap beats a simultaneous CALL.
        applyStimulus(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 32'h314, 22'd0, 30'd64, 32'd0, 1'b1, 32'h800);
        #1;
        checkOutput("trap_pc_next", pc_next, 32'h800);
        stepClock();
        checkOutput("trap_npc", npc_out, 32'h804);
        checkOutput("trap_run", {31'd0, delay_slot}, 32'd0);

        // Reset pulse in a delay slot restores nPC without a clock edge.
        applyStimulus(1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 32'h400, 22'd1, 30'd0, 32'd0, 1'b0, 32'd0);
        stepClock();
        checkOutput("pre_rst_slot", {31'd0, delay_slot}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_npc", npc_out, 32'h4);
        checkOutput("mid_rst_slot", {31'd0, delay_slot}, 32'd0);
        checkOutput("mid_rst_pcld", {31'd0, pc_ld}, 32'd0);
        #1;
        reset = 1'b0;
        applyIdle();
        stepClock();
        checkOutput("post_rst_npc", npc_out, 32'h8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
